// File: rtl/divider_if.sv
// Operand/result bundle for the serial divider: operands and select in, registered results out.
interface divider_if;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [1:0]  select;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        div_zero;

  modport master (
    output dividend, divisor, select,
    input  quotient, remainder, done, div_zero
  );

  modport slave (
    input  dividend, divisor, select,
    output quotient, remainder, done, div_zero
  );
endinterface

// File: rtl/divider.sv
// 32-bit restoring shift-subtract divider, one quotient bit per step, signed or unsigned via `sign`.
// Optional divide-by-zero trap enabled by defining DIVIDER_ZERO_TRAP_EN.
//
// state   | meaning
// ST_IDLE | no operation since reset; steps ignored
// ST_RUN  | division in progress, step counter > 0
// ST_DONE | quotient/remainder hold a completed result; steps ignored
module divider #(
  parameter logic sign = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  divider_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_STEP = 2'b01;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] dvd_q, dvs_q, part_q, quo_q;
  logic [31:0] quotient_q, remainder_q;
  logic        neg_quo_q, neg_rem_q;

  logic        load, step, last_step, zero_trap;
  logic [31:0] dividend_mag, divisor_mag;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] part_next, quo_next;

  always_comb begin
    load      = (bus.select == SEL_LOAD);
    step      = (bus.select == SEL_STEP) && (state_q == ST_RUN);
    last_step = step && (cnt_q == 6'd1);
`ifdef DIVIDER_ZERO_TRAP_EN
    zero_trap = load && (bus.divisor == 32'd0);
`else
    zero_trap = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    if (load)
      state_d = zero_trap ? ST_DONE : ST_RUN;
    else if (last_step)
      state_d = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Partial remainder is always below the divisor magnitude, so the trial
  // difference fits in 32 bits whenever the compare succeeds.
  always_comb begin
    dividend_mag = (sign && bus.dividend[31]) ? (32'd0 - bus.dividend) : bus.dividend;
    divisor_mag  = (sign && bus.divisor[31])  ? (32'd0 - bus.divisor)  : bus.divisor;
    shifted      = {part_q, dvd_q[31]};
    ge           = (shifted >= {1'b0, dvs_q});
    part_next    = ge ? (shifted[31:0] - dvs_q) : shifted[31:0];
    quo_next     = {quo_q[30:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= 6'd0;
      dvd_q       <= 32'd0;
      dvs_q       <= 32'd0;
      part_q      <= 32'd0;
      quo_q       <= 32'd0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else if (load) begin
      cnt_q       <= zero_trap ? 6'd0 : 6'd32;
      dvd_q       <= dividend_mag;
      dvs_q       <= divisor_mag;
      part_q      <= 32'd0;
      quo_q       <= 32'd0;
      quotient_q  <= zero_trap ? 32'hFFFF_FFFF : 32'd0;
      remainder_q <= zero_trap ? bus.dividend : 32'd0;
      neg_quo_q   <= sign & (bus.dividend[31] ^ bus.divisor[31]);
      neg_rem_q   <= sign & bus.dividend[31];
    end else if (step) begin
      cnt_q  <= cnt_q - 6'd1;
      dvd_q  <= {dvd_q[30:0], 1'b0};
      part_q <= part_next;
      quo_q  <= quo_next;
      if (last_step) begin
        quotient_q  <= neg_quo_q ? (32'd0 - quo_next)  : quo_next;
        remainder_q <= neg_rem_q ? (32'd0 - part_next) : part_next;
      end
    end
  end

`ifdef DIVIDER_ZERO_TRAP_EN
  logic div_zero_q;

  always_ff @(posedge clk) begin
    if (reset)     div_zero_q <= 1'b0;
    else if (load) div_zero_q <= zero_trap;
  end

  assign bus.div_zero = div_zero_q;
`else
  assign bus.div_zero = 1'b0;
`endif

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.done      = (state_q == ST_DONE);

endmodule
